// File: rtl/rv_pkg.sv
// Shared definitions for the instruction-memory responder: NOP encoding,
// boot-loader state encoding and the index-width helper.
package rv_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } load_state_t;

    function automatic int idx_width(input int depth_words);
        return $clog2(depth_words);
    endfunction

endpackage

// File: rtl/instr_mem_responder_if.sv
// Fetch-port and boot byte-stream signals between the core side and the responder.
interface instr_mem_responder_if #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
);
    logic [DATA_WIDTH-1:0] InstrAddr;
    logic [31:0]           Instr;
    logic                  InstrFault;
    logic                  LoadStart;
    logic [LEN_WIDTH-1:0]  LoadLen;
    logic                  LoadValid;
    logic [7:0]            LoadData;
    logic                  LoadReady;
    logic                  LoadBusy;
    logic                  LoadDone;

    modport master (
        output InstrAddr, LoadStart, LoadLen, LoadValid, LoadData,
        input  Instr, InstrFault, LoadReady, LoadBusy, LoadDone
    );

    modport slave (
        input  InstrAddr, LoadStart, LoadLen, LoadValid, LoadData,
        output Instr, InstrFault, LoadReady, LoadBusy, LoadDone
    );
endinterface

// File: rtl/instr_store.sv
// Word-addressed instruction array: one synchronous write port, one
// asynchronous read port, contents are never reset.
module instr_store #(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [31:0]           wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [31:0]           rdata
);
    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/instr_mem_responder.sv
// Fetch-side instruction responder with a boot-loader FSM that fills the
// store from a little-endian byte stream before the core is released.
module instr_mem_responder
    import rv_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int LEN_WIDTH   = 16
) (
    input logic                  clk,
    input logic                  rst,
    instr_mem_responder_if.slave bus
);
    localparam int IDX_W = idx_width(DEPTH_WORDS);

    load_state_t    state;
    logic [1:0]     byte_cnt;
    logic [IDX_W:0] ptr;
    logic [IDX_W:0] len;
    logic [23:0]    asm_word;
    logic           load_ready;
    logic           load_busy;
    logic           load_done;

    logic             accept;
    logic             word_wr;
    logic [IDX_W:0]   ptr_inc;
    logic [IDX_W:0]   len_req;
    logic [IDX_W-1:0] rd_idx;
    logic             aligned;
    logic             in_range;
    logic             fault;
    logic [31:0]      rd_data;

    // Length is one bit wider than the index so a full-store load fits.
    function automatic logic [IDX_W:0] clamp_len(input logic [LEN_WIDTH-1:0] req);
        if (32'(req) >= 32'(DEPTH_WORDS)) begin
            return (IDX_W+1)'(DEPTH_WORDS);
        end
        return (IDX_W+1)'(req);
    endfunction

    assign accept  = bus.LoadValid && load_ready;
    // A word completing in the reset cycle must not reach the store.
    assign word_wr = accept && (byte_cnt == 2'd3) && !rst;
    assign ptr_inc = ptr + (IDX_W+1)'(1);
    assign len_req = clamp_len(bus.LoadLen);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            byte_cnt   <= '0;
            ptr        <= '0;
            len        <= '0;
            asm_word   <= '0;
            load_ready <= 1'b0;
            load_busy  <= 1'b0;
            load_done  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.LoadStart) begin
                        len      <= len_req;
                        ptr      <= '0;
                        byte_cnt <= '0;
                        if (len_req == '0) begin
                            state      <= DONE;
                            load_ready <= 1'b0;
                            load_busy  <= 1'b0;
                            load_done  <= 1'b1;
                        end else begin
                            state      <= RECV;
                            load_ready <= 1'b1;
                            load_busy  <= 1'b1;
                            load_done  <= 1'b0;
                        end
                    end
                end
                RECV: begin
                    if (accept) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        case (byte_cnt)
                            2'd0: asm_word[7:0]   <= bus.LoadData;
                            2'd1: asm_word[15:8]  <= bus.LoadData;
                            2'd2: asm_word[23:16] <= bus.LoadData;
                            default: begin
                                ptr <= ptr_inc;
                                if (ptr_inc == len) begin
                                    state      <= DONE;
                                    load_ready <= 1'b0;
                                    load_busy  <= 1'b0;
                                    load_done  <= 1'b1;
                                end
                            end
                        endcase
                    end
                end
                default: begin
                    state      <= IDLE;
                    load_ready <= 1'b0;
                    load_busy  <= 1'b0;
                    load_done  <= 1'b0;
                end
            endcase
        end
    end

    instr_store #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .ADDR_WIDTH (IDX_W)
    ) u_store (
        .clk  (clk),
        .we   (word_wr),
        .waddr(ptr[IDX_W-1:0]),
        .wdata({bus.LoadData, asm_word}),
        .raddr(rd_idx),
        .rdata(rd_data)
    );

    assign rd_idx   = bus.InstrAddr[IDX_W+1:2];
    assign aligned  = (bus.InstrAddr[1:0] == 2'b00);
    assign in_range = (bus.InstrAddr[DATA_WIDTH-1:IDX_W+2] == '0);
    assign fault    = !aligned || !in_range;

    // Reads during a load return NOP, so a same-cycle write is never visible.
    assign bus.InstrFault = fault;
    assign bus.Instr      = (fault || state == RECV) ? NOP_INSTR : rd_data;
    assign bus.LoadReady  = load_ready;
    assign bus.LoadBusy   = load_busy;
    assign bus.LoadDone   = load_done;
endmodule

// File: tb/tb_instr_mem_responder.sv
// Directed-plus-random bench for instr_mem_responder against a word-array reference model.
module tb_instr_mem_responder;
    import rv_pkg::*;

    localparam int DW    = 32;
    localparam int DEPTH = 256;
    localparam int LW    = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instr_mem_responder_if #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

    instr_mem_responder #(
        .DATA_WIDTH (DW),
        .DEPTH_WORDS(DEPTH),
        .LEN_WIDTH  (LW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] model_mem [DEPTH];
    bit          model_wr  [DEPTH];
    logic [31:0] words [$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_status(input string tag, input bit rdy, input bit bsy, input bit dn);
        chk({tag, "_ready"}, 32'(bus.LoadReady), 32'(rdy));
        chk({tag, "_busy"},  32'(bus.LoadBusy),  32'(bsy));
        chk({tag, "_done"},  32'(bus.LoadDone),  32'(dn));
    endtask

    // Expected read result from the address rules and the model store.
    task automatic chk_read(input string tag, input logic [31:0] addr, input bit busy);
        bit flt;
        int w;
        flt = (addr % 4 != 0) || (addr >= DEPTH * 4);
        w   = int'(addr / 4);
        bus.InstrAddr = addr;
        #1;
        chk({tag, "_fault"}, 32'(bus.InstrFault), 32'(flt));
        if (flt || busy) chk(tag, bus.Instr, NOP_INSTR);
        else if (model_wr[w]) chk(tag, bus.Instr, model_mem[w]);
    endtask

    // gap < 0: random 0..3 idle cycles before each byte; otherwise fixed.
    task automatic do_load(input int len_req, input int gap, input string tag);
        int len;
        int g;
        len = (len_req > DEPTH) ? DEPTH : len_req;
        bus.LoadStart = 1'b1;
        bus.LoadLen   = LW'(len_req);
        step();
        bus.LoadStart = 1'b0;
        if (len == 0) begin
            chk_status({tag, "_zero"}, 1'b0, 1'b0, 1'b1);
            return;
        end
        chk_status({tag, "_start"}, 1'b1, 1'b1, 1'b0);
        for (int w = 0; w < len; w++) begin
            for (int k = 0; k < 4; k++) begin
                g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
                repeat (g) begin
                    bus.LoadValid = 1'b0;
                    bus.LoadData  = 8'($urandom);
                    step();
                end
                if (w == len - 1 && k == 3) chk_status({tag, "_last"}, 1'b1, 1'b1, 1'b0);
                if (len <= 4 && k == 0) chk_read({tag, "_busyrd"}, 32'h4, 1'b1);
                bus.LoadValid = 1'b1;
                bus.LoadData  = words[w][8*k +: 8];
                step();
                bus.LoadValid = 1'b0;
            end
            model_mem[w] = words[w];
            model_wr[w]  = 1'b1;
        end
        chk_status({tag, "_end"}, 1'b0, 1'b0, 1'b1);
    endtask

    // Start a 2-word load, feed nbytes, then reset while another byte is offered.
    task automatic abort_load(input int nbytes, input string tag);
        words.delete();
        words.push_back($urandom);
        words.push_back($urandom);
        bus.LoadStart = 1'b1;
        bus.LoadLen   = LW'(2);
        step();
        bus.LoadStart = 1'b0;
        for (int i = 0; i < nbytes; i++) begin
            bus.LoadValid = 1'b1;
            bus.LoadData  = words[i/4][8*(i%4) +: 8];
            step();
            if (i % 4 == 3) begin
                model_mem[i/4] = words[i/4];
                model_wr[i/4]  = 1'b1;
            end
        end
        rst           = 1'b1;
        bus.LoadValid = 1'b1;
        bus.LoadData  = words[nbytes/4][8*(nbytes%4) +: 8];
        step();
        rst           = 1'b0;
        bus.LoadValid = 1'b0;
        chk_status({tag, "_rst"}, 1'b0, 1'b0, 1'b0);
        chk_read({tag, "_w0"}, 32'h0, 1'b0);
        chk_read({tag, "_w1"}, 32'h4, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst           = 1'b1;
        bus.InstrAddr = '0;
        bus.LoadStart = 1'b0;
        bus.LoadLen   = '0;
        bus.LoadValid = 1'b0;
        bus.LoadData  = '0;
        for (int i = 0; i < DEPTH; i++) model_wr[i] = 1'b0;

        // 1: reset
        step();
        step();
        rst = 1'b0;
        chk_status("reset", 1'b0, 1'b0, 1'b0);
        chk_read("reset_rd0", 32'h0, 1'b0);

        // 2: two-word load without gaps
        words.delete();
        words.push_back(32'h00000013);
        words.push_back(32'h00100093);
        do_load(2, 0, "load2");
        chk_read("load2_rd0", 32'h0, 1'b0);
        chk_read("load2_rd4", 32'h4, 1'b0);
        chk("load2_lit4", bus.Instr, 32'h00100093);

        // 3: same load, valid low on alternate cycles
        do_load(2, 1, "gap2");
        chk_read("gap2_rd0", 32'h0, 1'b0);
        chk_read("gap2_rd4", 32'h4, 1'b0);

        // 4: misaligned and out-of-range fetches
        chk_read("mis6", 32'h6, 1'b0);
        chk_read("oor400", 32'h400, 1'b0);
        chk_read("oor_hi", 32'h8000_0000, 1'b0);
        chk_read("last_word", 32'h3FC, 1'b0);

        // random-length load with random gaps
        words.delete();
        for (int i = 0; i < 8; i++) words.push_back($urandom);
        do_load(int'($urandom_range(3, 8)), -1, "rnd");
        for (int i = 0; i < 8; i++) chk_read("rnd_rd", 32'(i * 4), 1'b0);

        // 5: zero-length load, then an oversize load clamped to the store depth
        do_load(0, 0, "len0");
        for (int i = 0; i < 8; i++) chk_read("len0_rd", 32'(i * 4), 1'b0);
        step();
        words.delete();
        for (int i = 0; i < DEPTH; i++) words.push_back($urandom);
        do_load(300, 0, "len300");
        for (int i = 0; i < 16; i++) chk_read("len300_rd", 32'($urandom_range(0, DEPTH - 1) * 4), 1'b0);
        chk_read("len300_first", 32'h0, 1'b0);
        chk_read("len300_last", 32'h3FC, 1'b0);

        // 6: reset mid-load, including a reset on the byte that would complete word 1
        abort_load(5, "abort5");
        abort_load(7, "abort7");
        words.delete();
        words.push_back($urandom);
        words.push_back($urandom);
        do_load(2, -1, "restart");
        chk_read("restart_rd0", 32'h0, 1'b0);
        chk_read("restart_rd4", 32'h4, 1'b0);
        chk_read("restart_rd8", 32'h8, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
